rns_compare_pipe: RTL

- Pipelined magnitude comparator for two operands in the RNS moduli set {2^N-1, 2^N, 2^N+1}; N=3 gives the {7,8,9} set.
- Each operand is converted to binary by mixed-radix/CRT reconstruction, then the two results are compared.
- Supports unsigned or signed (symmetric-range) interpretation per transaction, flags non-canonical residues, and carries a tag.
- Sits between RNS arithmetic units and control logic that needs ordering decisions. Valid/ready handshake, one result per cycle.

---
 rtl/rns_compare_pkg.sv | 56 +++++
 rtl/rns_to_bin_mrc.sv | 100 ++++++++++
 rtl/rns_compare_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rns_compare_pkg.sv
// Shared constants, width helpers and result type for the RNS {2^N-1, 2^N, 2^N+1} comparator.
package rns_compare_pkg;

  localparam int unsigned N_DEF     = 3;
  localparam int unsigned TAG_W_DEF = 4;

  // Moduli of the set
  function automatic int unsigned m1(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic int unsigned m2(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic int unsigned m3(input int unsigned n);
    return (32'd1 << n) + 32'd1;
  endfunction

  // Dynamic range M = 2^N * (2^2N - 1) and its half (signed threshold)
  function automatic int unsigned m_range(input int unsigned n);
    return m2(n) * ((32'd1 << (2 * n)) - 32'd1);
  endfunction

  function automatic int unsigned half_m(input int unsigned n);
    return m_range(n) / 32'd2;
  endfunction

  // Residue and reconstruction widths
  function automatic int unsigned r1_w(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned r2_w(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned r3_w(input int unsigned n);
    return n + 32'd1;
  endfunction

  function automatic int unsigned z_w(input int unsigned n);
    return 32'd2 * n;
  endfunction

  function automatic int unsigned x_w(input int unsigned n);
    return 32'd3 * n;
  endfunction

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

endpackage

// File: rtl/rns_to_bin_mrc.sv
// Two-stage RNS-to-binary reconstruction for one operand; X = {z_o, x2_o}.
module rns_to_bin_mrc
  import rns_compare_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic                   clk_i,
  input  logic                   s1_ld_i,
  input  logic                   s2_ld_i,
  input  logic [r1_w(N)-1:0]     x1_i,
  input  logic [r2_w(N)-1:0]     x2_i,
  input  logic [r3_w(N)-1:0]     x3_i,
  output logic [z_w(N)-1:0]      z_o,
  output logic [r2_w(N)-1:0]     x2_o,
  output logic                   err_o
);

  localparam int unsigned W1 = r1_w(N);
  localparam int unsigned W2 = r2_w(N);
  localparam int unsigned W3 = r3_w(N);
  localparam int unsigned ZW = z_w(N);
  localparam int unsigned DW = N + 3;

  localparam logic [W1-1:0] M1_V    = W1'(m1(N));
  localparam logic [W3-1:0] M3_W3   = W3'(m3(N));
  localparam logic [DW-1:0] M3_V    = DW'(m3(N));
  localparam logic [DW-1:0] M3X2_V  = DW'(2 * m3(N));

  logic [W1:0]   s1_sum;
  logic [W1-1:0] a_d;
  logic [DW-1:0] db;
  logic [W3-1:0] b_d;
  logic          err_d;

  logic [W1-1:0] a_q;
  logic [W3-1:0] b_q;
  logic [W2-1:0] x2_s1_q;
  logic          err_s1_q;

  logic [ZW-1:0] pa;
  logic [ZW-1:0] ra;
  logic [ZW:0]   pbw;
  logic [ZW-1:0] pb;
  logic [ZW-1:0] rb;
  logic [ZW:0]   s2_sum;
  logic [ZW-1:0] z_d;

  logic [ZW-1:0] z_q;
  logic [W2-1:0] x2_s2_q;
  logic          err_s2_q;

  // S1: mixed-radix digits a=(x1-x2) mod 2^N-1, b=(x2-x3) mod 2^N+1, canonical check
  always_comb begin
    s1_sum = {1'b0, x1_i} + {1'b0, ~x2_i};
    a_d    = s1_sum[W1-1:0] + W1'(s1_sum[W1]);
    if (a_d == M1_V) a_d = '0;
    // bias by 2*M3 keeps the difference positive even for out-of-range x3
    db = DW'(x2_i) + M3X2_V - DW'(x3_i);
    if (db >= M3X2_V)    db = db - M3X2_V;
    else if (db >= M3_V) db = db - M3_V;
    b_d   = W3'(db);
    err_d = (x1_i >= M1_V) || (x3_i >= M3_W3);
  end

  // S1 register
  always_ff @(posedge clk_i) begin
    if (s1_ld_i) begin
      a_q      <= a_d;
      b_q      <= b_d;
      x2_s1_q  <= x2_i;
      err_s1_q <= err_d;
    end
  end

  // S2: Z = (a*(2^N+1) + b*(2^N-1)) * 2^(N-1) mod 2^2N-1; scaling is a rotation
  always_comb begin
    pa     = {a_q, a_q};
    ra     = (pa << (N - 1)) | (pa >> (N + 1));
    pbw    = {b_q, W1'(0)} - (ZW + 1)'(b_q);
    pb     = ZW'(pbw);
    rb     = (pb << (N - 1)) | (pb >> (N + 1));
    s2_sum = {1'b0, ra} + {1'b0, rb};
    z_d    = s2_sum[ZW-1:0] + ZW'(s2_sum[ZW]);
    if (z_d == '1) z_d = '0;
  end

  // S2 register
  always_ff @(posedge clk_i) begin
    if (s2_ld_i) begin
      z_q      <= z_d;
      x2_s2_q  <= x2_s1_q;
      err_s2_q <= err_s1_q;
    end
  end

  assign z_o   = z_q;
  assign x2_o  = x2_s2_q;
  assign err_o = err_s2_q;

endmodule

// File: rtl/rns_compare_pipe.sv
// Three-stage pipelined RNS magnitude comparator with valid/ready handshake.
module rns_compare_pipe
  import rns_compare_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [N-1:0]     a1_in,
  input  logic [N-1:0]     a2_in,
  input  logic [N:0]       a3_in,
  input  logic [N-1:0]     b1_in,
  input  logic [N-1:0]     b2_in,
  input  logic [N:0]       b3_in,
  input  logic             signed_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic             lt_out,
  output logic             eq_out,
  output logic             gt_out,
  output logic             err_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned ZW = z_w(N);
  localparam int unsigned XW = x_w(N);
  localparam logic [XW-1:0] HALF_V = XW'(half_m(N));

  logic ld1_c, ld2_c, ld3_c;
  logic s1_ld_c, s2_ld_c, s3_ld_c;
  logic v1_q, v2_q, v3_q;

  logic             sg1_q, sg2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;

  logic [ZW-1:0] za, zb;
  logic [N-1:0]  x2a, x2b;
  logic          erra, errb;

  logic [XW-1:0] xa_c, xb_c;
  logic          neg_a_c, neg_b_c, err_c;
  cmp_e          cmp_c;
  logic          lt_d, eq_d, gt_d;

  logic             lt_q, eq_q, gt_q, err_q;
  logic [TAG_W-1:0] tag_q;

  // Stage advance: a stage loads when empty or its successor is loading/draining
  always_comb begin
    ld3_c   = !v3_q || out_ready_in;
    ld2_c   = !v2_q || ld3_c;
    ld1_c   = !v1_q || ld2_c;
    s1_ld_c = ld1_c && in_valid_in;
    s2_ld_c = ld2_c && v1_q;
    s3_ld_c = ld3_c && v2_q;
  end

  assign in_ready_out = ld1_c;

  // Per-stage valid bits
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (ld1_c) v1_q <= in_valid_in;
      if (ld2_c) v2_q <= v1_q;
      if (ld3_c) v3_q <= v2_q;
    end
  end

  // Sign mode and tag follow the data through S1/S2
  always_ff @(posedge clk_in) begin
    if (s1_ld_c) begin
      sg1_q  <= signed_in;
      tag1_q <= tag_in;
    end
    if (s2_ld_c) begin
      sg2_q  <= sg1_q;
      tag2_q <= tag1_q;
    end
  end

  rns_to_bin_mrc #(.N(N)) u_cvt_a (
    .clk_i   (clk_in),
    .s1_ld_i (s1_ld_c),
    .s2_ld_i (s2_ld_c),
    .x1_i    (a1_in),
    .x2_i    (a2_in),
    .x3_i    (a3_in),
    .z_o     (za),
    .x2_o    (x2a),
    .err_o   (erra)
  );

  rns_to_bin_mrc #(.N(N)) u_cvt_b (
    .clk_i   (clk_in),
    .s1_ld_i (s1_ld_c),
    .s2_ld_i (s2_ld_c),
    .x1_i    (b1_in),
    .x2_i    (b2_in),
    .x3_i    (b3_in),
    .z_o     (zb),
    .x2_o    (x2b),
    .err_o   (errb)
  );

  // S3 compare: in signed mode a differing sign decides, else plain magnitude
  always_comb begin
    xa_c    = {za, x2a};
    xb_c    = {zb, x2b};
    neg_a_c = sg2_q && (xa_c >= HALF_V);
    neg_b_c = sg2_q && (xb_c >= HALF_V);
    err_c   = erra || errb;
    cmp_c   = CMP_EQ;
    if (neg_a_c != neg_b_c) cmp_c = neg_a_c ? CMP_LT : CMP_GT;
    else if (xa_c < xb_c)   cmp_c = CMP_LT;
    else if (xa_c > xb_c)   cmp_c = CMP_GT;
    lt_d = !err_c && (cmp_c == CMP_LT);
    eq_d = !err_c && (cmp_c == CMP_EQ);
    gt_d = !err_c && (cmp_c == CMP_GT);
  end

  // S3 output register; holds while stalled
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      err_q <= 1'b0;
      tag_q <= '0;
    end else if (s3_ld_c) begin
      lt_q  <= lt_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      err_q <= err_c;
      tag_q <= tag2_q;
    end
  end

  assign out_valid_out = v3_q;
  assign lt_out        = lt_q;
  assign eq_out        = eq_q;
  assign gt_out        = gt_q;
  assign err_out       = err_q;
  assign tag_out       = tag_q;

endmodule
